ysyx_23060171_lsu: RTL and testbench

YSYX_23060171_LSU -- requirements
Module: ysyx_23060171_lsu

---
 rtl/ysyx_23060171_pkg.sv | 29 ++
 rtl/ysyx_23060171_lsu_align.sv | 51 +++++
 rtl/ysyx_23060171_lsu.sv | 167 ++++++++++++++++
 tb/tb_ysyx_23060171_lsu.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_23060171_pkg.sv
// Shared definitions for the ysyx_23060171 load/store unit.
//   lsu_state_e : controller states
//   SZ_*        : in_size encodings (byte, half, word, dword)
//   size_mask   : byte-enable pattern for an access size, before lane shift
package ysyx_23060171_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2,
    S_DONE = 2'd3
  } lsu_state_e;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  // (1 << 2^size) - 1 : one enable bit per byte of the access.
  function automatic logic [7:0] size_mask(input logic [1:0] size);
    case (size)
      SZ_B:    size_mask = 8'h01;
      SZ_H:    size_mask = 8'h03;
      SZ_W:    size_mask = 8'h0F;
      default: size_mask = 8'hFF;
    endcase
  endfunction

endpackage

// File: rtl/ysyx_23060171_lsu_align.sv
// Combinational lane steering for the LSU.
//   off       : byte offset of the access within the XLEN-wide memory word
//   size      : access size (SZ_*)
//   is_unsigned: zero-extend loads instead of sign-extending
//   wdata     : right-aligned store data  -> wdata_sh : store data moved to its lane
//   wmask     : byte enables for the store
//   rdata     : raw memory word           -> rdata_ext: extracted, extended load data
module ysyx_23060171_lsu_align
  import ysyx_23060171_pkg::*;
#(
  parameter  int XLEN = 32,
  localparam int BW   = XLEN / 8,
  localparam int OW   = $clog2(BW)
) (
  input  logic [OW-1:0]   off,
  input  logic [1:0]      size,
  input  logic            is_unsigned,
  input  logic [XLEN-1:0] wdata,
  input  logic [XLEN-1:0] rdata,
  output logic [BW-1:0]   wmask,
  output logic [XLEN-1:0] wdata_sh,
  output logic [XLEN-1:0] rdata_ext
);

  logic [7:0]      mask8;
  logic [XLEN-1:0] rd_sh;
  logic [63:0]     keep64;
  logic [XLEN-1:0] keep;
  logic            sbit;

  always_comb begin
    mask8    = size_mask(size);
    wmask    = mask8[BW-1:0] << off;
    wdata_sh = wdata << {off, 3'b000};
    rd_sh    = rdata >> {off, 3'b000};

    // keep marks the bits that belong to the access; everything above is
    // filled with the sign bit (or zero for unsigned loads).
    keep64 = '1;
    sbit   = 1'b0;
    case (size)
      SZ_B: begin keep64 = 64'h0000_0000_0000_00FF; sbit = rd_sh[7];  end
      SZ_H: begin keep64 = 64'h0000_0000_0000_FFFF; sbit = rd_sh[15]; end
      SZ_W: begin keep64 = 64'h0000_0000_FFFF_FFFF; sbit = rd_sh[31]; end
      default: ;
    endcase
    keep      = keep64[XLEN-1:0];
    rdata_ext = (rd_sh & keep) | ({XLEN{sbit & ~is_unsigned}} & ~keep);
  end

endmodule

// File: rtl/ysyx_23060171_lsu.sv
// Load/store unit: accepts one access upstream, issues at most one memory
// request/response pair, and presents a single result downstream.
//   clk, rst               : clock, asynchronous active-low reset
//   in_*                   : upstream access (addr, wdata, tag, ren, wen, size, unsigned)
//   mem_req_* / mem_*      : memory request channel (aligned addr, wen, wdata, wmask)
//   mem_resp_* / mem_rdata : memory response channel
//   out_*                  : downstream result (data, tag, misalign flag)
//   dbg_state              : current controller state
//
// Handshakes: every channel transfers on a rising edge where its valid and
// ready are both high. A valid, once raised, is held together with its
// payload until that transfer happens. All valids/readies driven by this
// block are decoded from the state flop only, so none depends on an input.
module ysyx_23060171_lsu
  import ysyx_23060171_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int AW   = 32,
  parameter int TW   = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [AW-1:0]     in_addr,
  input  logic [XLEN-1:0]   in_wdata,
  input  logic [TW-1:0]     in_tag,
  input  logic              in_ren,
  input  logic              in_wen,
  input  logic [1:0]        in_size,
  input  logic              in_unsigned,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [AW-1:0]     mem_addr,
  output logic              mem_wen,
  output logic [XLEN-1:0]   mem_wdata,
  output logic [XLEN/8-1:0] mem_wmask,
  input  logic              mem_resp_valid,
  output logic              mem_resp_ready,
  input  logic [XLEN-1:0]   mem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_data,
  output logic [TW-1:0]     out_tag,
  output logic              out_misalign,
  output logic [1:0]        dbg_state
);

  localparam int BW = XLEN / 8;
  localparam int OW = $clog2(BW);

  lsu_state_e      state_q, state_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [TW-1:0]   tag_q, tag_d;
  logic            wen_q, wen_d;
  logic [1:0]      size_q, size_d;
  logic            uns_q, uns_d;
  logic [XLEN-1:0] out_data_q, out_data_d;
  logic            out_misalign_q, out_misalign_d;

  logic            aligned;
  logic            mem_op;
  logic [BW-1:0]   lane_mask;
  logic [XLEN-1:0] lane_wdata;
  logic [XLEN-1:0] load_data;

  ysyx_23060171_lsu_align #(.XLEN(XLEN)) u_align (
    .off        (addr_q[OW-1:0]),
    .size       (size_q),
    .is_unsigned(uns_q),
    .wdata      (wdata_q),
    .rdata      (mem_rdata),
    .wmask      (lane_mask),
    .wdata_sh   (lane_wdata),
    .rdata_ext  (load_data)
  );

  // A dword is never aligned on a 32-bit datapath: it cannot fit one beat.
  always_comb begin
    case (in_size)
      SZ_B:    aligned = 1'b1;
      SZ_H:    aligned = ~in_addr[0];
      SZ_W:    aligned = (in_addr[1:0] == 2'b00);
      default: aligned = (XLEN == 64) && (in_addr[2:0] == 3'b000);
    endcase
    mem_op = in_ren | in_wen;
  end

  always_comb begin
    state_d        = state_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    tag_d          = tag_q;
    wen_d          = wen_q;
    size_d         = size_q;
    uns_d          = uns_q;
    out_data_d     = out_data_q;
    out_misalign_d = out_misalign_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          addr_d         = in_addr;
          wdata_d        = in_wdata;
          tag_d          = in_tag;
          wen_d          = in_wen;
          size_d         = in_size;
          uns_d          = in_unsigned;
          out_data_d     = '0;
          out_misalign_d = mem_op & ~aligned;
          state_d        = (mem_op && aligned) ? S_REQ : S_DONE;
        end
      end
      S_REQ: begin
        if (mem_req_ready) state_d = S_RESP;
      end
      S_RESP: begin
        if (mem_resp_valid) begin
          // Stores (including ren&wen) only wait for the ack; no data returns.
          out_data_d = wen_q ? '0 : load_data;
          state_d    = S_DONE;
        end
      end
      default: begin
        if (out_ready) state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= S_IDLE;
      addr_q         <= '0;
      wdata_q        <= '0;
      tag_q          <= '0;
      wen_q          <= 1'b0;
      size_q         <= SZ_B;
      uns_q          <= 1'b0;
      out_data_q     <= '0;
      out_misalign_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      addr_q         <= addr_d;
      wdata_q        <= wdata_d;
      tag_q          <= tag_d;
      wen_q          <= wen_d;
      size_q         <= size_d;
      uns_q          <= uns_d;
      out_data_q     <= out_data_d;
      out_misalign_q <= out_misalign_d;
    end
  end

  assign in_ready       = (state_q == S_IDLE);
  assign mem_req_valid  = (state_q == S_REQ);
  assign mem_resp_ready = (state_q == S_RESP);
  assign out_valid      = (state_q == S_DONE);
  assign mem_addr       = {addr_q[AW-1:OW], {OW{1'b0}}};
  assign mem_wen        = wen_q & mem_req_valid;
  assign mem_wdata      = lane_wdata;
  assign mem_wmask      = (mem_req_valid && wen_q) ? lane_mask : '0;
  assign out_data       = out_data_q;
  assign out_tag        = tag_q;
  assign out_misalign   = out_misalign_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_ysyx_23060171_lsu.sv
module tb_ysyx_23060171_lsu;
  import ysyx_23060171_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst32, rst64;

  // ---------------- XLEN=32 instance ----------------
  logic        in_valid, in_ready, in_ren, in_wen, in_unsigned;
  logic [31:0] in_addr, in_wdata;
  logic [4:0]  in_tag;
  logic [1:0]  in_size;
  logic        mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid, mem_resp_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wmask;
  logic        out_valid, out_ready, out_misalign;
  logic [31:0] out_data;
  logic [4:0]  out_tag;
  logic [1:0]  dbg_state;

  ysyx_23060171_lsu #(.XLEN(32), .AW(32), .TW(5)) dut32 (
    .clk(clk), .rst(rst32),
    .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_wdata(in_wdata),
    .in_tag(in_tag), .in_ren(in_ren), .in_wen(in_wen), .in_size(in_size),
    .in_unsigned(in_unsigned),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_resp_ready(mem_resp_ready), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag),
    .out_misalign(out_misalign), .dbg_state(dbg_state)
  );

  // ---------------- XLEN=64 instance ----------------
  logic        b_in_valid, b_in_ready, b_in_ren, b_in_wen, b_in_unsigned;
  logic [31:0] b_in_addr;
  logic [63:0] b_in_wdata;
  logic [4:0]  b_in_tag;
  logic [1:0]  b_in_size;
  logic        b_mem_req_valid, b_mem_req_ready, b_mem_wen, b_mem_resp_valid, b_mem_resp_ready;
  logic [31:0] b_mem_addr;
  logic [63:0] b_mem_wdata, b_mem_rdata;
  logic [7:0]  b_mem_wmask;
  logic        b_out_valid, b_out_ready, b_out_misalign;
  logic [63:0] b_out_data;
  logic [4:0]  b_out_tag;
  logic [1:0]  b_dbg_state;

  ysyx_23060171_lsu #(.XLEN(64), .AW(32), .TW(5)) dut64 (
    .clk(clk), .rst(rst64),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_addr(b_in_addr), .in_wdata(b_in_wdata),
    .in_tag(b_in_tag), .in_ren(b_in_ren), .in_wen(b_in_wen), .in_size(b_in_size),
    .in_unsigned(b_in_unsigned),
    .mem_req_valid(b_mem_req_valid), .mem_req_ready(b_mem_req_ready), .mem_addr(b_mem_addr),
    .mem_wen(b_mem_wen), .mem_wdata(b_mem_wdata), .mem_wmask(b_mem_wmask),
    .mem_resp_valid(b_mem_resp_valid), .mem_resp_ready(b_mem_resp_ready), .mem_rdata(b_mem_rdata),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data), .out_tag(b_out_tag),
    .out_misalign(b_out_misalign), .dbg_state(b_dbg_state)
  );

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        ren, wen;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr, wdata, rdata;
    logic [4:0]  tag;
    logic        exp_req;
    logic [31:0] exp_maddr;
    logic [3:0]  exp_wmask;
    logic [31:0] exp_wdata;
    logic        exp_wen;
    logic [31:0] exp_data;
    logic        exp_mis;
    int          exp_lat;
  } vec_t;

  vec_t vecs[13];

  // Drives one access with a zero-wait memory and an always-ready consumer.
  task automatic run_vec(input int idx, input vec_t v);
    int          lat;
    logic        saw;
    logic [31:0] ma, wd;
    logic [3:0]  wm;
    logic        we;
    @(negedge clk);
    chk($sformatf("v%0d_in_ready", idx), in_ready, 1);
    in_valid = 1; in_addr = v.addr; in_wdata = v.wdata; in_tag = v.tag;
    in_ren = v.ren; in_wen = v.wen; in_size = v.size; in_unsigned = v.uns;
    mem_rdata = v.rdata;
    @(posedge clk); #1;
    in_valid = 0;
    lat = 1; saw = 0; ma = 0; wd = 0; wm = 0; we = 0;
    while (!out_valid && lat < 20) begin
      if (mem_req_valid && !saw) begin
        saw = 1; ma = mem_addr; wm = mem_wmask; wd = mem_wdata; we = mem_wen;
      end
      @(posedge clk); #1;
      lat++;
    end
    chk($sformatf("v%0d_latency", idx), lat, v.exp_lat);
    chk($sformatf("v%0d_mem_req_seen", idx), saw, v.exp_req);
    chk($sformatf("v%0d_out_data", idx), out_data, v.exp_data);
    chk($sformatf("v%0d_out_misalign", idx), out_misalign, v.exp_mis);
    chk($sformatf("v%0d_out_tag", idx), out_tag, v.tag);
    if (v.exp_req) begin
      chk($sformatf("v%0d_mem_addr", idx), ma, v.exp_maddr);
      chk($sformatf("v%0d_mem_wmask", idx), wm, v.exp_wmask);
      chk($sformatf("v%0d_mem_wdata", idx), wd, v.exp_wdata);
      chk($sformatf("v%0d_mem_wen", idx), we, v.exp_wen);
    end
    @(posedge clk); #1;
  endtask

  task automatic run64(input string nm, input logic [31:0] addr, input logic [1:0] size,
                       input logic uns, input logic [63:0] rdata, input logic [63:0] exp);
    int lat;
    @(negedge clk);
    b_in_valid = 1; b_in_addr = addr; b_in_size = size; b_in_unsigned = uns;
    b_in_ren = 1; b_in_wen = 0; b_mem_rdata = rdata;
    @(posedge clk); #1;
    b_in_valid = 0;
    lat = 1;
    while (!b_out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({nm, "_latency"}, lat, 3);
    chk({nm, "_out_data"}, b_out_data, exp);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //            ren wen size uns addr          wdata         rdata         tag   req maddr         wmask    wdata         wen data          mis lat
    vecs[0]  = '{1, 0, SZ_W, 0, 32'h8000_0004, 32'h0,        32'hDEAD_BEEF, 5'd1,  1, 32'h8000_0004, 4'b0000, 32'h0,        0, 32'hDEAD_BEEF, 0, 3};
    vecs[1]  = '{1, 0, SZ_B, 0, 32'h8000_0003, 32'h0,        32'h8011_2233, 5'd2,  1, 32'h8000_0000, 4'b0000, 32'h0,        0, 32'hFFFF_FF80, 0, 3};
    vecs[2]  = '{1, 0, SZ_B, 1, 32'h8000_0003, 32'h0,        32'h8011_2233, 5'd3,  1, 32'h8000_0000, 4'b0000, 32'h0,        0, 32'h0000_0080, 0, 3};
    vecs[3]  = '{0, 1, SZ_H, 0, 32'h8000_0002, 32'h0000_ABCD, 32'h5555_5555, 5'd4, 1, 32'h8000_0000, 4'b1100, 32'hABCD_0000, 1, 32'h0,        0, 3};
    vecs[4]  = '{1, 0, SZ_W, 0, 32'h8000_0002, 32'h0,        32'hDEAD_BEEF, 5'd5,  0, 32'h0,        4'b0000, 32'h0,        0, 32'h0,        1, 1};
    vecs[5]  = '{0, 0, SZ_W, 0, 32'h8000_0006, 32'h1234_5678, 32'hDEAD_BEEF, 5'd31, 0, 32'h0,       4'b0000, 32'h0,        0, 32'h0,        0, 1};
    vecs[6]  = '{1, 0, SZ_H, 0, 32'h8000_0002, 32'h0,        32'h8001_1234, 5'd6,  1, 32'h8000_0000, 4'b0000, 32'h0,        0, 32'hFFFF_8001, 0, 3};
    vecs[7]  = '{1, 0, SZ_H, 1, 32'h8000_0000, 32'h0,        32'h1234_F00D, 5'd7,  1, 32'h8000_0000, 4'b0000, 32'h0,        0, 32'h0000_F00D, 0, 3};
    vecs[8]  = '{0, 1, SZ_B, 0, 32'h8000_0001, 32'hFFFF_FFA5, 32'h0,        5'd8,  1, 32'h8000_0000, 4'b0010, 32'hFFFF_A500, 1, 32'h0,        0, 3};
    vecs[9]  = '{1, 0, SZ_D, 0, 32'h8000_0000, 32'h0,        32'hDEAD_BEEF, 5'd9,  0, 32'h0,        4'b0000, 32'h0,        0, 32'h0,        1, 1};
    vecs[10] = '{1, 1, SZ_W, 0, 32'h8000_0008, 32'h1122_3344, 32'hCAFE_BABE, 5'd10, 1, 32'h8000_0008, 4'b1111, 32'h1122_3344, 1, 32'h0,        0, 3};
    vecs[11] = '{1, 0, SZ_H, 0, 32'h8000_0001, 32'h0,        32'hDEAD_BEEF, 5'd11, 0, 32'h0,        4'b0000, 32'h0,        0, 32'h0,        1, 1};
    vecs[12] = '{1, 0, SZ_B, 0, 32'h8000_0000, 32'h0,        32'h0000_007F, 5'd12, 1, 32'h8000_0000, 4'b0000, 32'h0,        0, 32'h0000_007F, 0, 3};

    // reset
    rst32 = 0; rst64 = 0;
    in_valid = 0; in_addr = 0; in_wdata = 0; in_tag = 0; in_ren = 0; in_wen = 0;
    in_size = 0; in_unsigned = 0;
    mem_req_ready = 1; mem_resp_valid = 1; mem_rdata = 0; out_ready = 1;
    b_in_valid = 0; b_in_addr = 0; b_in_wdata = 0; b_in_tag = 0; b_in_ren = 0; b_in_wen = 0;
    b_in_size = 0; b_in_unsigned = 0;
    b_mem_req_ready = 1; b_mem_resp_valid = 1; b_mem_rdata = 0; b_out_ready = 1;
    #12;
    chk("rst_mem_req_valid", mem_req_valid, 0);
    chk("rst_mem_resp_ready", mem_resp_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_tag", out_tag, 0);
    chk("rst_out_misalign", out_misalign, 0);
    chk("rst_mem_wmask", mem_wmask, 0);
    @(negedge clk);
    rst32 = 1; rst64 = 1;
    @(posedge clk); #1;
    chk("rst_in_ready_after", in_ready, 1);

    for (int i = 0; i < 13; i++) run_vec(i, vecs[i]);

    // memory stall then consumer stall
    @(negedge clk);
    mem_req_ready = 0; mem_rdata = 32'h0BAD_F00D;
    in_valid = 1; in_addr = 32'h8000_0010; in_ren = 1; in_wen = 0;
    in_size = SZ_W; in_unsigned = 0; in_tag = 5'd17;
    @(posedge clk); #1;
    in_valid = 0;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("stall_req_valid_%0d", i), mem_req_valid, 1);
      chk($sformatf("stall_req_addr_%0d", i), mem_addr, 32'h8000_0010);
      chk($sformatf("stall_req_in_ready_%0d", i), in_ready, 0);
      @(posedge clk); #1;
    end
    mem_req_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("stall_out_valid_%0d", i), out_valid, 1);
      chk($sformatf("stall_out_data_%0d", i), out_data, 32'h0BAD_F00D);
      chk($sformatf("stall_out_tag_%0d", i), out_tag, 5'd17);
      chk($sformatf("stall_out_in_ready_%0d", i), in_ready, 0);
      @(posedge clk); #1;
    end
    out_ready = 1;
    @(posedge clk); #1;
    chk("stall_released_out_valid", out_valid, 0);
    chk("stall_released_in_ready", in_ready, 1);

    // XLEN=64: reset while waiting for a response
    @(negedge clk);
    b_mem_resp_valid = 0;
    b_in_valid = 1; b_in_addr = 32'h8; b_in_ren = 1; b_in_wen = 0;
    b_in_size = SZ_D; b_in_unsigned = 0; b_in_tag = 5'd9;
    @(posedge clk); #1;
    b_in_valid = 0;
    @(posedge clk); #1;
    chk("x64_in_resp_state", b_dbg_state, S_RESP);
    chk("x64_in_resp_ready", b_mem_resp_ready, 1);
    #2;
    rst64 = 0;
    #1;
    chk("x64_rst_in_ready", b_in_ready, 1);
    chk("x64_rst_req_valid", b_mem_req_valid, 0);
    chk("x64_rst_resp_ready", b_mem_resp_ready, 0);
    chk("x64_rst_out_valid", b_out_valid, 0);
    chk("x64_rst_out_data", b_out_data, 0);
    chk("x64_rst_out_tag", b_out_tag, 0);
    chk("x64_rst_wmask", b_mem_wmask, 0);
    @(negedge clk);
    rst64 = 1;
    b_mem_resp_valid = 1; b_mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk($sformatf("x64_late_resp_ignored_%0d", i), b_out_valid, 0);
    end
    run64("x64_ld", 32'h10, SZ_D, 0, 64'h8877_6655_4433_2211, 64'h8877_6655_4433_2211);
    run64("x64_lw", 32'h4, SZ_W, 0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_8000_0000);
    run64("x64_lbu", 32'h7, SZ_B, 1, 64'hAB00_0000_0000_0000, 64'h0000_0000_0000_00AB);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
